// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer
// Fetches instruction words (and the immediate word for mvi) from a
// synchronous program ROM, presents them to the 9-bit core as IR/DIN,
// pulses Run, waits for Done and advances the program counter.
// Handles halt (opcode 3'b111), stop requests and a Done watchdog.
//
// Optional feature: define SINGLE_STEP_EN to add the Step input and a
// PAUSE state entered after every completed instruction.
//
// Every output is a register updated in the same always_ff as the state,
// so there is no combinational path from Done or MemData to any output.

module instr_fetch_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stop,
`ifdef SINGLE_STEP_EN
  input  logic              Step,
`endif
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [8:0]        MemData,
  input  logic              Done,
  output logic [8:0]        IR,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Fault
);

  // Watchdog counter is wide enough to hold DONE_TIMEOUT and saturates.
  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_F_I    = 4'd1,
    ST_L_I    = 4'd2,
    ST_F_D    = 4'd3,
    ST_L_D    = 4'd4,
    ST_RUN    = 4'd5,
    ST_EXEC   = 4'd6,
    ST_HALTED = 4'd7,
`ifdef SINGLE_STEP_EN
    ST_PAUSE  = 4'd9,
`endif
    ST_FAULT  = 4'd8
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic               mem_rd_en_r;
  logic [8:0]         ir_r;
  logic [8:0]         din_r;
  logic               run_r;
  logic               busy_r;
  logic               halted_r;
  logic               fault_r;
  logic               stop_pend_r;
  logic [CNT_W-1:0]   timeout_cnt_r;
  logic [ADDR_W-1:0]  pc_inc_s;

  // Saturating increment of the watchdog counter.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] res;
    if (cnt == CNT_MAX) begin
      res = cnt;
    end else begin
      res = cnt + CNT_ONE;
    end
    return res;
  endfunction

  // Next program counter; wraps naturally at the address width.
  assign pc_inc_s = pc_r + PC_ONE;

  assign MemAddr = mem_addr_r;
  assign MemRdEn = mem_rd_en_r;
  assign IR      = ir_r;
  assign DIN     = din_r;
  assign Run     = run_r;
  assign Busy    = busy_r;
  assign Halted  = halted_r;
  assign Fault   = fault_r;

  // Sequencer FSM with registered outputs; outputs are written on the
  // transition into the state they belong to.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= {ADDR_W{1'b0}};
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_rd_en_r   <= 1'b0;
      ir_r          <= 9'h000;
      din_r         <= 9'h000;
      run_r         <= 1'b0;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
      fault_r       <= 1'b0;
      stop_pend_r   <= 1'b0;
      timeout_cnt_r <= {CNT_W{1'b0}};
    end else begin
      // Strobes last one cycle unless a transition re-asserts them.
      run_r       <= 1'b0;
      mem_rd_en_r <= 1'b0;

      // A stop request is only remembered while an instruction is in flight.
      if (busy_r && Stop) begin
        stop_pend_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE: begin
          // Stop wins over a simultaneous Start.
          if (Start && !Stop) begin
            state_r     <= ST_F_I;
            mem_rd_en_r <= 1'b1;
            busy_r      <= 1'b1;
          end
        end

        ST_F_I: begin
          state_r <= ST_L_I;
        end

        ST_L_I: begin
          ir_r       <= MemData;
          pc_r       <= pc_inc_s;
          mem_addr_r <= pc_inc_s;
          case (MemData[8:6])
            OP_HALT: begin
              state_r     <= ST_HALTED;
              busy_r      <= 1'b0;
              halted_r    <= 1'b1;
              stop_pend_r <= 1'b0;
            end
            OP_MVI: begin
              state_r     <= ST_F_D;
              mem_rd_en_r <= 1'b1;
            end
            default: begin
              state_r <= ST_RUN;
              run_r   <= 1'b1;
            end
          endcase
        end

        ST_F_D: begin
          state_r <= ST_L_D;
        end

        ST_L_D: begin
          din_r      <= MemData;
          pc_r       <= pc_inc_s;
          mem_addr_r <= pc_inc_s;
          state_r    <= ST_RUN;
          run_r      <= 1'b1;
        end

        ST_RUN: begin
          timeout_cnt_r <= {CNT_W{1'b0}};
          state_r       <= ST_EXEC;
        end

        ST_EXEC: begin
          if (Done) begin
            if (stop_pend_r) begin
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
              stop_pend_r <= 1'b0;
            end else begin
`ifdef SINGLE_STEP_EN
              state_r     <= ST_PAUSE;
`else
              state_r     <= ST_F_I;
              mem_rd_en_r <= 1'b1;
`endif
            end
          end else if (timeout_cnt_r == CNT_LAST) begin
            // Last allowed EXEC cycle passed without Done.
            state_r     <= ST_FAULT;
            busy_r      <= 1'b0;
            fault_r     <= 1'b1;
            stop_pend_r <= 1'b0;
          end else begin
            timeout_cnt_r <= cnt_step(timeout_cnt_r);
          end
        end

`ifdef SINGLE_STEP_EN
        ST_PAUSE: begin
          // Stop (live or pending) takes priority over Step.
          if (stop_pend_r || Stop) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            stop_pend_r <= 1'b0;
          end else if (Step) begin
            state_r     <= ST_F_I;
            mem_rd_en_r <= 1'b1;
          end
        end
`endif

        ST_HALTED, ST_FAULT: begin
          // Restart from address 0; Stop has no effect here.
          if (Start) begin
            state_r     <= ST_F_I;
            pc_r        <= {ADDR_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_rd_en_r <= 1'b1;
            busy_r      <= 1'b1;
            halted_r    <= 1'b0;
            fault_r     <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: return to a safe, quiescent state.
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          halted_r    <= 1'b0;
          fault_r     <= 1'b0;
          stop_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed testbench for instr_fetch_sequencer (default build).
// A small synchronous ROM model answers MemRdEn with one cycle latency.
// Outputs are sampled 1 time unit after each rising edge; inputs change there
// too, so they are seen by the following rising edge.

module tb_instr_fetch_sequencer;

  localparam int ADDR_W = 5;

  logic              Clock   = 1'b0;
  logic              Reset   = 1'b1;
  logic              Start   = 1'b0;
  logic              Stop    = 1'b0;
  logic              Done    = 1'b0;
  logic [8:0]        MemData = 9'h000;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRdEn;
  logic [8:0]        IR;
  logic [8:0]        DIN;
  logic              Run;
  logic              Busy;
  logic              Halted;
  logic              Fault;

  logic [8:0] rom [0:31];

  int tests  = 0;
  int failed = 0;

  instr_fetch_sequencer #(
    .ADDR_W(ADDR_W),
    .DONE_TIMEOUT(15)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Start  (Start),
    .Stop   (Stop),
    .MemAddr(MemAddr),
    .MemRdEn(MemRdEn),
    .MemData(MemData),
    .Done   (Done),
    .IR     (IR),
    .DIN    (DIN),
    .Run    (Run),
    .Busy   (Busy),
    .Halted (Halted),
    .Fault  (Fault)
  );

  always #5 Clock = ~Clock;

  // Synchronous program ROM, one cycle read latency.
  always @(posedge Clock) begin
    if (MemRdEn) begin
      MemData <= rom[MemAddr];
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // {Run, Busy, Halted, Fault, MemRdEn}
  function automatic logic [31:0] status();
    return 32'({Run, Busy, Halted, Fault, MemRdEn});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i] = 9'h000;
    end
    rom[0] = 9'h00A;  // mv
    rom[1] = 9'h058;  // mvi
    rom[2] = 9'h155;  // immediate
    rom[3] = 9'h081;  // add
    rom[4] = 9'h1C0;  // halt

    // Reset state
    repeat (2) tick();
    chk("rst_status", status(), 32'h00);
    chk("rst_addr", 32'(MemAddr), 32'd0);
    chk("rst_ir", 32'(IR), 32'h000);
    chk("rst_din", 32'(DIN), 32'h000);
    Reset = 1'b0;
    tick();
    chk("idle_status", status(), 32'h00);

    // mv at address 0
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("mv_fi_status", status(), 32'b01001);
    chk("mv_fi_addr", 32'(MemAddr), 32'd0);
    tick();
    chk("mv_li_status", status(), 32'b01000);
    tick();
    chk("mv_run_status", status(), 32'b11000);
    chk("mv_ir", 32'(IR), 32'h00A);
    chk("mv_pc", 32'(MemAddr), 32'd1);
    Done = 1'b1;  // seen first in RUN (ignored), then in EXEC
    tick();
    chk("mv_exec_status", status(), 32'b01000);
    tick();
    Done = 1'b0;
    chk("mv_next_fi_status", status(), 32'b01001);
    chk("mv_next_fi_addr", 32'(MemAddr), 32'd1);

    // mvi at address 1, immediate at 2
    tick();
    tick();
    chk("mvi_ir", 32'(IR), 32'h058);
    chk("mvi_fd_status", status(), 32'b01001);
    chk("mvi_fd_addr", 32'(MemAddr), 32'd2);
    chk("mvi_din_hold", 32'(DIN), 32'h000);
    tick();
    tick();
    chk("mvi_din", 32'(DIN), 32'h155);
    chk("mvi_run_status", status(), 32'b11000);
    chk("mvi_pc", 32'(MemAddr), 32'd3);
    Done = 1'b1;
    tick();
    tick();
    Done = 1'b0;
    chk("mvi_next_fi_status", status(), 32'b01001);
    chk("mvi_next_fi_addr", 32'(MemAddr), 32'd3);

    // add at address 3 with Stop during EXEC, Done on 3rd EXEC cycle
    tick();
    tick();
    chk("add_ir", 32'(IR), 32'h081);
    chk("add_run_status", status(), 32'b11000);
    chk("add_din_kept", 32'(DIN), 32'h155);
    tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    tick();
    chk("add_exec_status", status(), 32'b01000);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("stop_idle_status", status(), 32'h00);
    chk("stop_idle_addr", 32'(MemAddr), 32'd4);
    tick();
    chk("idle_hold_status", status(), 32'h00);

    // Start and Stop together in IDLE
    Start = 1'b1;
    Stop  = 1'b1;
    tick();
    chk("startstop_idle_a", status(), 32'h00);
    tick();
    Start = 1'b0;
    Stop  = 1'b0;
    chk("startstop_idle_b", status(), 32'h00);

    // Resume at PC=4, which holds halt
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("resume_status", status(), 32'b01001);
    chk("resume_addr", 32'(MemAddr), 32'd4);
    tick();
    tick();
    chk("halt_status", status(), 32'b00100);
    chk("halt_ir", 32'(IR), 32'h1C0);
    chk("halt_pc", 32'(MemAddr), 32'd5);
    tick();
    chk("halt_no_run", status(), 32'b00100);

    // Restart from HALTED at address 0, then let the watchdog expire
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("halt_restart_status", status(), 32'b01001);
    chk("halt_restart_addr", 32'(MemAddr), 32'd0);
    tick();
    tick();
    chk("to_run_status", status(), 32'b11000);
    repeat (15) tick();
    chk("to_pre_fault_status", status(), 32'b01000);
    tick();
    chk("to_fault_status", status(), 32'b00010);
    chk("to_fault_addr", 32'(MemAddr), 32'd1);
    tick();
    chk("to_fault_hold", status(), 32'b00010);

    // Restart from FAULT at address 0
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("fault_restart_status", status(), 32'b01001);
    chk("fault_restart_addr", 32'(MemAddr), 32'd0);

    // Fill ROM with mv and hold Done high: one fetch every 4 cycles,
    // PC runs 1..31 and wraps to 0.
    for (int i = 0; i < 32; i++) begin
      rom[i] = 9'h00A;
    end
    Done = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      repeat (4) tick();
      chk("wrap_fetch_addr", 32'(MemAddr), 32'(i % 32));
      chk("wrap_fetch_rden", 32'(MemRdEn), 32'd1);
    end

    // Reset asserted during EXEC clears outputs immediately
    tick();
    tick();
    tick();
    chk("pre_reset_busy", status(), 32'b01000);
    Reset = 1'b1;
    #1;
    chk("async_rst_status", status(), 32'h00);
    chk("async_rst_addr", 32'(MemAddr), 32'd0);
    chk("async_rst_ir", 32'(IR), 32'h000);
    chk("async_rst_din", 32'(DIN), 32'h000);
    Done = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    chk("post_rst_status", status(), 32'h00);
    tick();
    chk("post_rst_no_run", status(), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
